// File: rtl/controller_pkg.sv
// Shared types and sizing for the game-controller responder.
`timescale 1ns/1ps
package controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam int BUTTON_W    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(BUTTON_W + 1);

endpackage

// File: rtl/sync_2ff_m.sv
// Single-bit two-flop synchronizer for asynchronous host strobes.
`timescale 1ns/1ps
module sync_2ff_m
    import controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/controller_responder_m.sv
// Device side of the serial controller link: latches a button snapshot on the
// host latch strobe and shifts it out MSB first, active-low, on host clock edges.
`timescale 1ns/1ps
module controller_responder_m
    import controller_pkg::*;
#(
    parameter logic TRAILING_B = 1'b1
)
(
    input  logic                clk_12_5875,
    input  logic                rst_B,
    input  logic                controller_clk,
    input  logic                controller_latch,
    input  logic [BUTTON_W-1:0] buttons_in,
    input  logic                buttons_valid,
    output logic                buttons_ready,
    output logic                data_out_B,
    output logic                poll_done,
    output logic [7:0]          poll_count
);

    localparam int                MSB  = BUTTON_W - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BUTTON_W - 1);

    logic                clk_s;
    logic                latch_s;
    logic                clk_s_d;
    logic                clk_rise;

    state_e              state;
    state_e              state_nxt;
    logic [BUTTON_W-1:0] snapshot;
    logic [BUTTON_W-1:0] shreg;
    logic [BUTTON_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                dout_nxt;
    logic                done_nxt;

    sync_2ff_m u_sync_clk (
        .clk   (clk_12_5875),
        .rst_n (rst_B),
        .d     (controller_clk),
        .q     (clk_s)
    );

    sync_2ff_m u_sync_latch (
        .clk   (clk_12_5875),
        .rst_n (rst_B),
        .d     (controller_latch),
        .q     (latch_s)
    );

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            clk_s_d <= 1'b0;
        end else begin
            clk_s_d <= clk_s;
        end
    end

    assign clk_rise = clk_s & ~clk_s_d;

    // Snapshot is frozen while the host latches so a poll never sees a torn value.
    assign buttons_ready = ~latch_s;

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            snapshot <= '0;
        end else if (buttons_valid && buttons_ready) begin
            snapshot <= buttons_in;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        dout_nxt  = data_out_B;
        done_nxt  = 1'b0;
        if (latch_s) begin
            state_nxt = ST_LOAD;
            shreg_nxt = snapshot;
            cnt_nxt   = '0;
            dout_nxt  = ~snapshot[MSB];
        end else begin
            case (state)
                ST_IDLE: dout_nxt = 1'b1;
                ST_LOAD: begin
                    state_nxt = ST_SHIFT;
                    dout_nxt  = ~shreg[MSB];
                end
                ST_SHIFT: begin
                    dout_nxt = ~shreg[MSB];
                    if (clk_rise) begin
                        shreg_nxt = {shreg[MSB-1:0], 1'b0};
                        cnt_nxt   = cnt + CNT_W'(1);
                        // Output is registered from next-state values, so the
                        // trailing level lands on the same cycle as poll_done.
                        if (cnt == LAST) begin
                            state_nxt = ST_DONE;
                            dout_nxt  = TRAILING_B;
                            done_nxt  = 1'b1;
                        end else begin
                            dout_nxt = ~shreg[MSB-1];
                        end
                    end
                end
                ST_DONE: dout_nxt = TRAILING_B;
                default: begin
                    state_nxt = ST_IDLE;
                    dout_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            data_out_B <= 1'b1;
            poll_done  <= 1'b0;
            poll_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            data_out_B <= dout_nxt;
            poll_done  <= done_nxt;
            if (done_nxt) begin
                poll_count <= poll_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_controller_responder_m.sv
// Directed bench for controller_responder_m: one task per scenario, each with
// hand-computed expected bit streams and counter values.
`timescale 1ns/1ps
module tb_controller_responder_m;

    logic       clk = 1'b0;
    logic       rst_B;
    logic       controller_clk;
    logic       controller_latch;
    logic [7:0] buttons_in;
    logic       buttons_valid;

    logic       buttons_ready, data_out_B, poll_done;
    logic [7:0] poll_count;
    logic       buttons_ready0, data_out_B0, poll_done0;
    logic [7:0] poll_count0;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int done_seen = 0;
    int done_seen0 = 0;

    always #40 clk = ~clk;

    controller_responder_m #(.TRAILING_B(1'b1)) dut (
        .clk_12_5875      (clk),
        .rst_B            (rst_B),
        .controller_clk   (controller_clk),
        .controller_latch (controller_latch),
        .buttons_in       (buttons_in),
        .buttons_valid    (buttons_valid),
        .buttons_ready    (buttons_ready),
        .data_out_B       (data_out_B),
        .poll_done        (poll_done),
        .poll_count       (poll_count)
    );

    controller_responder_m #(.TRAILING_B(1'b0)) dut_t0 (
        .clk_12_5875      (clk),
        .rst_B            (rst_B),
        .controller_clk   (controller_clk),
        .controller_latch (controller_latch),
        .buttons_in       (buttons_in),
        .buttons_valid    (buttons_valid),
        .buttons_ready    (buttons_ready0),
        .data_out_B       (data_out_B0),
        .poll_done        (poll_done0),
        .poll_count       (poll_count0)
    );

    always @(negedge clk) begin
        if (poll_done === 1'b1)  done_seen  <= done_seen + 1;
        if (poll_done0 === 1'b1) done_seen0 <= done_seen0 + 1;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_buttons(input logic [7:0] v);
        buttons_in    = v;
        buttons_valid = 1'b1;
        for (int i = 0; i < 8 && buttons_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (buttons_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: buttons_ready=%b required 1", buttons_ready);
        end
        @(negedge clk);
        buttons_valid = 1'b0;
    endtask

    // Sample k is taken just before the k-th rising host clock edge; sample
    // [edges] is taken after the last edge.
    task automatic do_poll(input int edges, input int half, input int latch_cyc,
                           output logic [15:0] s1, output logic [15:0] s0);
        s1 = '0;
        s0 = '0;
        controller_latch = 1'b1;
        wait_cyc(latch_cyc);
        controller_latch = 1'b0;
        wait_cyc(half);
        for (int k = 0; k < edges; k++) begin
            s1[k] = data_out_B;
            s0[k] = data_out_B0;
            controller_clk = 1'b1;
            wait_cyc(half);
            controller_clk = 1'b0;
            wait_cyc(half);
        end
        s1[edges] = data_out_B;
        s0[edges] = data_out_B0;
    endtask

    task automatic test_reset();
        rst_B = 1'b0;
        controller_clk = 1'b0;
        controller_latch = 1'b0;
        buttons_in = 8'h00;
        buttons_valid = 1'b0;
        wait_cyc(2);
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL reset_data: data_out_B=%b required 1", data_out_B); end
        checks++;
        if (poll_done !== 1'b0) begin errors++; $display("FAIL reset_done: poll_done=%b required 0", poll_done); end
        checks++;
        if (poll_count !== 8'd0) begin errors++; $display("FAIL reset_count: poll_count=%0d required 0", poll_count); end
        checks++;
        if (buttons_ready !== 1'b1 || buttons_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: buttons_ready=%b/%b required 1", buttons_ready, buttons_ready0);
        end
        rst_B = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_basic_poll();
        logic [15:0] s1, s0;
        logic [8:0]  exp;
        int d0;
        exp = 9'b101101110;
        load_buttons(8'b10001001);
        d0 = done_seen;
        do_poll(8, 6, 13, s1, s0);
        for (int k = 0; k <= 8; k++) begin
            checks++;
            if (s1[k] !== exp[k]) begin
                errors++;
                $display("FAIL basic_bit%0d: data_out_B=%b required %b", k, s1[k], exp[k]);
            end
        end
        exp_count++;
        checks++;
        if (done_seen - d0 != 1) begin errors++; $display("FAIL basic_done: poll_done pulses=%0d required 1", done_seen - d0); end
        checks++;
        if (poll_count !== 8'(exp_count)) begin errors++; $display("FAIL basic_count: poll_count=%0d required %0d", poll_count, exp_count); end
    endtask

    task automatic test_trailing();
        logic [15:0] s1, s0;
        logic [9:0]  exp;
        int d0;
        exp = 10'b0010011011;
        load_buttons(8'b00100110);
        d0 = done_seen0;
        do_poll(10, 6, 13, s1, s0);
        for (int k = 0; k <= 9; k++) begin
            checks++;
            if (s0[k] !== exp[k]) begin
                errors++;
                $display("FAIL trailing0_bit%0d: data_out_B=%b required %b", k, s0[k], exp[k]);
            end
        end
        checks++;
        if (s1[9] !== 1'b1) begin errors++; $display("FAIL trailing1_bit9: data_out_B=%b required 1", s1[9]); end
        exp_count++;
        checks++;
        if (done_seen0 - d0 != 1) begin errors++; $display("FAIL trailing_done: poll_done pulses=%0d required 1", done_seen0 - d0); end
        checks++;
        if (poll_count !== 8'(exp_count) || poll_count0 !== 8'(exp_count)) begin
            errors++;
            $display("FAIL trailing_count: poll_count=%0d/%0d required %0d", poll_count, poll_count0, exp_count);
        end
    endtask

    task automatic test_latch_priority();
        int d0;
        load_buttons(8'b01000000);
        d0 = done_seen;
        controller_latch = 1'b1;
        wait_cyc(5);
        controller_clk = 1'b1;
        wait_cyc(6);
        controller_clk = 1'b0;
        wait_cyc(6);
        controller_latch = 1'b0;
        wait_cyc(6);
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL latchprio_bit7: data_out_B=%b required 1", data_out_B); end
        controller_clk = 1'b1;
        wait_cyc(6);
        controller_clk = 1'b0;
        wait_cyc(6);
        checks++;
        if (data_out_B !== 1'b0) begin errors++; $display("FAIL latchprio_bit6: data_out_B=%b required 0", data_out_B); end
        checks++;
        if (done_seen != d0) begin errors++; $display("FAIL latchprio_done: poll_done pulses=%0d required 0", done_seen - d0); end
    endtask

    task automatic test_handshake();
        logic [15:0] s1, s0;
        int n;
        load_buttons(8'h5A);
        controller_latch = 1'b1;
        wait_cyc(4);
        buttons_in = 8'hFF;
        buttons_valid = 1'b1;
        wait_cyc(3);
        checks++;
        if (buttons_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_low: buttons_ready=%b required 0", buttons_ready); end
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL hs_hold_a: data_out_B=%b required 1", data_out_B); end
        wait_cyc(3);
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL hs_hold_b: data_out_B=%b required 1", data_out_B); end
        controller_latch = 1'b0;
        n = 0;
        while (buttons_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (buttons_ready !== 1'b1 || n > 3) begin
            errors++;
            $display("FAIL hs_accept: buttons_ready=%b after %0d cycles required 1 within 3", buttons_ready, n);
        end
        @(negedge clk);
        buttons_valid = 1'b0;
        wait_cyc(4);
        do_poll(8, 6, 13, s1, s0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (s1[k] !== 1'b0) begin
                errors++;
                $display("FAIL hs_bit%0d: data_out_B=%b required 0", k, s1[k]);
            end
        end
        exp_count++;
        checks++;
        if (poll_count !== 8'(exp_count)) begin errors++; $display("FAIL hs_count: poll_count=%0d required %0d", poll_count, exp_count); end
    endtask

    task automatic test_async_reset();
        int d0;
        load_buttons(8'h80);
        controller_latch = 1'b1;
        wait_cyc(13);
        controller_latch = 1'b0;
        wait_cyc(6);
        checks++;
        if (data_out_B !== 1'b0) begin errors++; $display("FAIL ar_pre_data: data_out_B=%b required 0", data_out_B); end
        checks++;
        if (poll_count !== 8'(exp_count)) begin errors++; $display("FAIL ar_pre_count: poll_count=%0d required %0d", poll_count, exp_count); end
        #10;
        rst_B = 1'b0;
        #1;
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL ar_data: data_out_B=%b required 1", data_out_B); end
        checks++;
        if (poll_count !== 8'd0) begin errors++; $display("FAIL ar_count: poll_count=%0d required 0", poll_count); end
        checks++;
        if (buttons_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: buttons_ready=%b required 1", buttons_ready); end
        exp_count = 0;
        @(negedge clk);
        rst_B = 1'b1;
        wait_cyc(2);
        d0 = done_seen;
        controller_clk = 1'b1;
        wait_cyc(6);
        controller_clk = 1'b0;
        wait_cyc(6);
        checks++;
        if (data_out_B !== 1'b1) begin errors++; $display("FAIL idle_clk_data: data_out_B=%b required 1", data_out_B); end
        checks++;
        if (done_seen != d0 || poll_count !== 8'd0) begin
            errors++;
            $display("FAIL idle_clk_count: pulses=%0d poll_count=%0d required 0/0", done_seen - d0, poll_count);
        end
    endtask

    task automatic test_restart_wrap();
        logic [15:0] s1, s0;
        logic [8:0]  exp;
        int d0;
        exp = 9'b111110010;
        load_buttons(8'b10110000);
        d0 = done_seen;
        controller_latch = 1'b1;
        wait_cyc(13);
        controller_latch = 1'b0;
        wait_cyc(6);
        for (int k = 0; k < 3; k++) begin
            controller_clk = 1'b1;
            wait_cyc(6);
            controller_clk = 1'b0;
            wait_cyc(6);
        end
        checks++;
        if (done_seen != d0) begin errors++; $display("FAIL restart_abort_done: pulses=%0d required 0", done_seen - d0); end
        do_poll(8, 6, 13, s1, s0);
        for (int k = 0; k <= 8; k++) begin
            checks++;
            if (s1[k] !== exp[k]) begin
                errors++;
                $display("FAIL restart_bit%0d: data_out_B=%b required %b", k, s1[k], exp[k]);
            end
        end
        exp_count++;
        checks++;
        if (done_seen - d0 != 1 || poll_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL restart_count: pulses=%0d poll_count=%0d required 1/%0d", done_seen - d0, poll_count, exp_count);
        end
        while (exp_count < 255) begin
            do_poll(8, 5, 5, s1, s0);
            exp_count++;
        end
        checks++;
        if (poll_count !== 8'd255) begin errors++; $display("FAIL wrap_255: poll_count=%0d required 255", poll_count); end
        do_poll(8, 5, 5, s1, s0);
        checks++;
        if (poll_count !== 8'd0) begin errors++; $display("FAIL wrap_0: poll_count=%0d required 0", poll_count); end
    endtask

    initial begin
        test_reset();
        test_basic_poll();
        test_trailing();
        test_latch_priority();
        test_handshake();
        test_async_reset();
        test_restart_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
